// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the FSM state encoding, load-mode codes and requester identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic [1:0] MODE_WORD    = 2'b00;
  localparam logic [1:0] MODE_HALF_S  = 2'b01;
  localparam logic [1:0] MODE_HALF_U  = 2'b10;
  localparam logic [1:0] MODE_ILLEGAL = 2'b11;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // Stores always move a full word; loads follow their mode field.
  function automatic logic is_word_access(input logic we, input logic [1:0] mode);
    return we || (mode == MODE_WORD);
  endfunction

endpackage

// File: rtl/mem_access_arbiter_align_check.sv
// Combinational legality check of one access: alignment, range and load mode.
// Sized in 33 bits so an address near the top of the 32-bit space cannot wrap into range.
module mem_arb_align_check
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4000
) (
  input  logic        we,
  input  logic [1:0]  mode,
  input  logic [31:0] addr,
  output logic        err
);

  logic [32:0] addr_ext;
  logic [32:0] last_byte;

  always_comb begin
    addr_ext  = {1'b0, addr};
    last_byte = addr_ext;
    err       = 1'b0;
    if (is_word_access(we, mode)) begin
      last_byte = addr_ext + 33'd3;
      err       = (addr[1:0] != 2'b00) || (last_byte >= 33'(MEM_BYTES));
    end else if (mode == MODE_ILLEGAL) begin
      err = 1'b1;
    end else begin
      last_byte = addr_ext + 33'd1;
      err       = addr[0] || (last_byte >= 33'(MEM_BYTES));
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter/sequencer between the MEM-stage port (A) and the debug loader (B)
// in front of the big-endian data memory; illegal accesses are answered without a strobe.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned MEM_BYTES     = 4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [1:0]  a_mode,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [1:0]  b_mode,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  load_mode,
  output logic [31:0] address,
  output logic [31:0] write_data,
  input  logic [31:0] read_data
);

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e       state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic             we_q, we_d;
  logic [1:0]       mode_q, mode_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_done_q, a_done_d, b_done_q, b_done_d;
  logic        a_err_q, a_err_d, b_err_q, b_err_d;
  logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic        mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [1:0]  load_mode_q, load_mode_d;
  logic [31:0] address_q, address_d, write_data_q, write_data_d;

  // Winner of the current IDLE cycle: the pointer decides only when both ask.
  logic        win_b;
  logic        win_we;
  logic [1:0]  win_mode;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;
  logic        chk_err;

  always_comb begin
    win_b     = (a_req && b_req) ? (rr_q == OWNER_B) : b_req;
    win_we    = win_b ? b_we    : a_we;
    win_mode  = win_b ? b_mode  : a_mode;
    win_addr  = win_b ? b_addr  : a_addr;
    win_wdata = win_b ? b_wdata : a_wdata;
  end

  mem_arb_align_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_align (
    .we  (win_we),
    .mode(win_mode),
    .addr(win_addr),
    .err (chk_err)
  );

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    owner_d      = owner_q;
    we_d         = we_q;
    mode_d       = mode_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    a_gnt_d      = 1'b0;
    b_gnt_d      = 1'b0;
    a_done_d     = 1'b0;
    b_done_d     = 1'b0;
    a_err_d      = 1'b0;
    b_err_d      = 1'b0;
    a_rdata_d    = '0;
    b_rdata_d    = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    load_mode_d  = '0;
    address_d    = '0;
    write_data_d = '0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d = win_b ? OWNER_B : OWNER_A;
          rr_d    = win_b ? OWNER_A : OWNER_B;
          we_d    = win_we;
          mode_d  = win_mode;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          a_gnt_d = ~win_b;
          b_gnt_d = win_b;
          if (chk_err) begin
            // Rejected at grant: answer next cycle, memory never sees it.
            state_d  = RESP;
            a_done_d = ~win_b;
            b_done_d = win_b;
            a_err_d  = ~win_b;
            b_err_d  = win_b;
          end else begin
            state_d      = ACCESS;
            cnt_d        = '0;
            mem_read_d   = ~win_we;
            mem_write_d  = win_we;
            load_mode_d  = win_mode;
            address_d    = win_addr;
            write_data_d = win_wdata;
          end
        end
      end

      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = RESP;
          a_done_d = (owner_q == OWNER_A);
          b_done_d = (owner_q == OWNER_B);
          if (!we_q) begin
            a_rdata_d = (owner_q == OWNER_A) ? read_data : '0;
            b_rdata_d = (owner_q == OWNER_B) ? read_data : '0;
          end
        end else begin
          cnt_d        = cnt_q + CNT_W'(1);
          mem_read_d   = ~we_q;
          mem_write_d  = we_q;
          load_mode_d  = mode_q;
          address_d    = addr_q;
          write_data_d = wdata_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_q         <= OWNER_A;
      owner_q      <= OWNER_A;
      we_q         <= 1'b0;
      mode_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      load_mode_q  <= '0;
      address_q    <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      mode_q       <= mode_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      a_gnt_q      <= a_gnt_d;
      b_gnt_q      <= b_gnt_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      a_err_q      <= a_err_d;
      b_err_q      <= b_err_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      load_mode_q  <= load_mode_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
    end
  end

  assign a_gnt      = a_gnt_q;
  assign b_gnt      = b_gnt_q;
  assign a_done     = a_done_q;
  assign b_done     = b_done_q;
  assign a_err      = a_err_q;
  assign b_err      = b_err_q;
  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign load_mode  = load_mode_q;
  assign address    = address_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a behavioural big-endian 4000-byte memory.
// Latencies are counted in cycles after the cycle in which a request is first presented.
module tb_mem_access_arbiter;

  typedef struct packed {
    logic        we;
    logic [1:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    int          gnt_cyc;
    int          done_cyc;
    logic        err;
    logic [31:0] rdata;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [1:0]  a_mode = '0, b_mode = '0;
  logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic        a_gnt, a_done, a_err, b_gnt, b_done, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        mem_read, mem_write;
  logic [1:0]  load_mode;
  logic [31:0] address, write_data;
  logic [31:0] read_data;

  int passed = 0;
  int total  = 0;

  int strobe_cycles = 0, overlap = 0, dual = 0, stray = 0, idle_mem = 0;
  int a_done_cnt = 0, b_done_cnt = 0;

  logic [137:0] allout;
  assign allout = {a_gnt, a_done, a_err, a_rdata, b_gnt, b_done, b_err, b_rdata,
                   mem_read, mem_write, load_mode, address, write_data};

  always #5 clk = ~clk;

  mem_access_arbiter #(
    .ACCESS_CYCLES(2),
    .MEM_BYTES(4000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_mode(a_mode), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_mode(b_mode), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .load_mode(load_mode),
    .address(address), .write_data(write_data), .read_data(read_data)
  );

  // Behavioural data memory: big-endian, writes on the clock, combinational reads.
  logic [7:0] mem [0:3999];

  function automatic logic [7:0] rdb(input logic [31:0] a);
    if (a < 32'd4000) return mem[a[11:0]];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_write && address <= 32'd3996) begin
      mem[address[11:0]]          <= write_data[31:24];
      mem[address[11:0] + 12'd1]  <= write_data[23:16];
      mem[address[11:0] + 12'd2]  <= write_data[15:8];
      mem[address[11:0] + 12'd3]  <= write_data[7:0];
    end
  end

  logic [7:0] rb0, rb1, rb2, rb3;
  always_comb begin
    rb0 = rdb(address);
    rb1 = rdb(address + 32'd1);
    rb2 = rdb(address + 32'd2);
    rb3 = rdb(address + 32'd3);
    read_data = '0;
    if (mem_read) begin
      case (load_mode)
        2'b00:   read_data = {rb0, rb1, rb2, rb3};
        2'b01:   read_data = {{16{rb0[7]}}, rb0, rb1};
        2'b10:   read_data = {16'h0000, rb0, rb1};
        default: read_data = '0;
      endcase
    end
  end

  // Protocol monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (mem_read || mem_write) strobe_cycles++;
    if (mem_read && mem_write) overlap++;
    if ((a_gnt && b_gnt) || (a_done && b_done)) dual++;
    if (!(mem_read || mem_write) && ((address != 0) || (write_data != 0) || (load_mode != 0)))
      idle_mem++;
    if (!a_done && (a_err || a_rdata != 0)) stray++;
    if (!b_done && (b_err || b_rdata != 0)) stray++;
    if (a_done) a_done_cnt++;
    if (b_done) b_done_cnt++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic req_t mk(input logic we, input logic [1:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.mode = mode; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  // Presents up to two requests in the same IDLE cycle and collects per-port results.
  task automatic issue(input logic a_en, input req_t ar, input logic b_en, input req_t br,
                       output res_t a_res, output res_t b_res);
    a_res = '0;
    b_res = '0;
    tick();
    a_req = a_en; a_we = ar.we; a_mode = ar.mode; a_addr = ar.addr; a_wdata = ar.wdata;
    b_req = b_en; b_we = br.we; b_mode = br.mode; b_addr = br.addr; b_wdata = br.wdata;
    for (int k = 1; k <= 40 && (a_req || b_req); k++) begin
      tick();
      if (a_gnt) a_res.gnt_cyc = k;
      if (b_gnt) b_res.gnt_cyc = k;
      if (a_done && a_req) begin
        a_res.done_cyc = k; a_res.err = a_err; a_res.rdata = a_rdata; a_req = 1'b0;
      end
      if (b_done && b_req) begin
        b_res.done_cyc = k; b_res.err = b_err; b_res.rdata = b_rdata; b_req = 1'b0;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic test_reset();
    res_t ra, rb;
    int d0;
    tick(); tick();
    total++;
    if (allout !== '0) $display("FAIL reset_outputs: got %h expected 0", allout);
    else passed++;
    rst_n = 1'b1;
    tick();
    a_req = 1'b1; a_we = 1'b1; a_mode = 2'b00; a_addr = 32'h100; a_wdata = 32'h11223344;
    tick();
    total++;
    if ({a_gnt, mem_write} !== 2'b11) $display("FAIL reset_pre_access: gnt/wr %b expected 11", {a_gnt, mem_write});
    else passed++;
    d0 = a_done_cnt;
    rst_n = 1'b0;
    a_req = 1'b0;
    tick();
    total++;
    if (allout !== '0) $display("FAIL reset_mid_access_1: got %h expected 0", allout);
    else passed++;
    tick();
    total++;
    if (allout !== '0) $display("FAIL reset_mid_access_2: got %h expected 0", allout);
    else passed++;
    rst_n = 1'b1;
    tick(); tick();
    total++;
    if (a_done_cnt - d0 !== 0) $display("FAIL reset_no_done: done pulses %0d expected 0", a_done_cnt - d0);
    else passed++;
    issue(1'b1, mk(1'b0, 2'b00, 32'h100, 0), 1'b1, mk(1'b0, 2'b00, 32'h100, 0), ra, rb);
    total++;
    if (ra.gnt_cyc !== 1 || rb.gnt_cyc !== 5)
      $display("FAIL reset_rr_ptr: gnt A@%0d B@%0d expected A@1 B@5", ra.gnt_cyc, rb.gnt_cyc);
    else passed++;
  endtask

  task automatic test_store_load();
    res_t ra, rb;
    int s0;
    s0 = strobe_cycles;
    issue(1'b1, mk(1'b1, 2'b00, 32'h10, 32'hDEADBEEF), 1'b0, '0, ra, rb);
    total++;
    if (ra.gnt_cyc !== 1 || ra.done_cyc !== 3)
      $display("FAIL store_latency: gnt@%0d done@%0d expected gnt@1 done@3", ra.gnt_cyc, ra.done_cyc);
    else passed++;
    total++;
    if (ra.err !== 1'b0 || ra.rdata !== 32'h0)
      $display("FAIL store_resp: err %b rdata %h expected err 0 rdata 0", ra.err, ra.rdata);
    else passed++;
    total++;
    if (strobe_cycles - s0 !== 2) $display("FAIL store_strobe_len: got %0d expected 2", strobe_cycles - s0);
    else passed++;
    issue(1'b1, mk(1'b0, 2'b00, 32'h10, 0), 1'b0, '0, ra, rb);
    total++;
    if (ra.rdata !== 32'hDEADBEEF || ra.done_cyc !== 3)
      $display("FAIL load_word: rdata %h done@%0d expected deadbeef done@3", ra.rdata, ra.done_cyc);
    else passed++;
    issue(1'b1, mk(1'b1, 2'b00, 32'd3996, 32'hCAFEF00D), 1'b0, '0, ra, rb);
    issue(1'b1, mk(1'b0, 2'b00, 32'd3996, 0), 1'b0, '0, ra, rb);
    total++;
    if (ra.err !== 1'b0 || ra.rdata !== 32'hCAFEF00D)
      $display("FAIL load_word_last: err %b rdata %h expected err 0 rdata cafef00d", ra.err, ra.rdata);
    else passed++;
  endtask

  task automatic test_half_loads();
    res_t ra, rb;
    logic [1:0]  h_mode [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [31:0] h_addr [4] = '{32'h20, 32'h20, 32'h22, 32'd3998};
    logic [31:0] h_exp  [4] = '{32'hFFFF8001, 32'h00008001, 32'h00001234, 32'h0000F00D};
    issue(1'b1, mk(1'b1, 2'b00, 32'h20, 32'h80011234), 1'b0, '0, ra, rb);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, '0, 1'b1, mk(1'b0, h_mode[i], h_addr[i], 0), ra, rb);
      total++;
      if (rb.err !== 1'b0 || rb.rdata !== h_exp[i] || rb.done_cyc !== 3)
        $display("FAIL half_load_%0d: err %b rdata %h done@%0d expected err 0 rdata %h done@3",
                 i, rb.err, rb.rdata, rb.done_cyc, h_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_errors();
    res_t ra, rb, r;
    int s0;
    logic        e_we   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [1:0]  e_mode [7] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10};
    logic [31:0] e_addr [7] = '{32'h13, 32'h21, 32'd3998, 32'h0, 32'd4000, 32'h12, 32'd3999};
    s0 = strobe_cycles;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) begin
        issue(1'b1, mk(e_we[i], e_mode[i], e_addr[i], 32'h55AA55AA), 1'b0, '0, ra, rb);
        r = ra;
      end else begin
        issue(1'b0, '0, 1'b1, mk(e_we[i], e_mode[i], e_addr[i], 32'h55AA55AA), ra, rb);
        r = rb;
      end
      total++;
      if (r.err !== 1'b1 || r.done_cyc !== 1 || r.gnt_cyc !== 1 || r.rdata !== 32'h0)
        $display("FAIL err_case_%0d: err %b gnt@%0d done@%0d rdata %h expected err 1 gnt@1 done@1 rdata 0",
                 i, r.err, r.gnt_cyc, r.done_cyc, r.rdata);
      else passed++;
    end
    total++;
    if (strobe_cycles - s0 !== 0) $display("FAIL err_no_strobe: strobe cycles %0d expected 0", strobe_cycles - s0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    res_t ra, rb;
    issue(1'b0, '0, 1'b1, mk(1'b0, 2'b00, 32'h10, 0), ra, rb);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, mk(1'b0, 2'b00, 32'h10, 0), 1'b1, mk(1'b0, 2'b00, 32'h20, 0), ra, rb);
      total++;
      if (ra.gnt_cyc !== 1 || rb.gnt_cyc !== 5 || rb.done_cyc !== 7)
        $display("FAIL rr_round_%0d: gnt A@%0d B@%0d doneB@%0d expected A@1 B@5 doneB@7",
                 i, ra.gnt_cyc, rb.gnt_cyc, rb.done_cyc);
      else passed++;
      total++;
      if (ra.rdata !== 32'hDEADBEEF || rb.rdata !== 32'h80011234)
        $display("FAIL rr_data_%0d: A %h B %h expected deadbeef 80011234", i, ra.rdata, rb.rdata);
      else passed++;
    end
    total++;
    if (overlap !== 0 || dual !== 0)
      $display("FAIL strobe_overlap: overlap %0d dual %0d expected 0 0", overlap, dual);
    else passed++;
  endtask

  task automatic test_rr_pointer();
    res_t ra, rb;
    issue(1'b1, mk(1'b0, 2'b00, 32'h10, 0), 1'b0, '0, ra, rb);
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, '0, 1'b1, mk(1'b0, 2'b00, 32'h20, 0), ra, rb);
      total++;
      if (rb.gnt_cyc !== 1 || rb.done_cyc !== 3 || rb.rdata !== 32'h80011234)
        $display("FAIL b_alone_%0d: gnt@%0d done@%0d rdata %h expected gnt@1 done@3 rdata 80011234",
                 i, rb.gnt_cyc, rb.done_cyc, rb.rdata);
      else passed++;
    end
    issue(1'b1, mk(1'b0, 2'b00, 32'h10, 0), 1'b1, mk(1'b0, 2'b00, 32'h20, 0), ra, rb);
    total++;
    if (ra.gnt_cyc !== 1 || rb.gnt_cyc !== 5)
      $display("FAIL rr_after_b: gnt A@%0d B@%0d expected A@1 B@5", ra.gnt_cyc, rb.gnt_cyc);
    else passed++;
    total++;
    if (stray !== 0 || idle_mem !== 0)
      $display("FAIL quiet_outputs: stray %0d idle_mem %0d expected 0 0", stray, idle_mem);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_half_loads();
    test_errors();
    test_back_to_back();
    test_rr_pointer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
